// File: rtl/imem_responder.sv
// imem_responder: memory side of the instruction fetch interface.
// A word-addressed store is read when a request is accepted. The word is
// held until the response cycle, which comes LATENCY cycles after acceptance.
// A redirect (flush) discards any fetch in flight. A misaligned or
// out-of-range fetch returns NOP_WORD with rsp_fault set.
// Optional feature macro: IMEM_PREFETCH_EN. When it is defined, a one-entry
// prefetch buffer holds the word after the last good response, and a hit on
// that buffer is answered in one cycle.
module imem_responder #(
  parameter int          DEPTH    = 256,
  parameter int          LATENCY  = 2,
  parameter logic [31:0] NOP_WORD = 32'hC8000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [31:0]              req_addr,
  output logic                     req_ready,
  input  logic                     flush,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_instr,
  output logic                     rsp_fault,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  output logic [7:0]               fault_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [31:0] mem [DEPTH];
  logic [31:0] data_reg;
  logic        fault_reg;
  logic [31:0] last_instr_reg;
  logic        last_fault_reg;
  logic [7:0]  fault_count_reg;
  logic        accept;
  logic        req_fault;
  logic        fast_path;
  logic [AW-1:0] req_idx;

  assign req_idx   = req_addr[AW+1:2];
  assign req_fault = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH));

  // A flush frees the port, even while a fetch is waiting, so that the
  // redirect target can be accepted in the same cycle.
  assign req_ready = (state_reg != WAIT) || flush;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_reg == RESP) && !flush;

  // Outside the response pulse the outputs show the last delivered response.
  assign rsp_instr   = rsp_valid ? (fault_reg ? NOP_WORD : data_reg) : last_instr_reg;
  assign rsp_fault   = rsp_valid ? fault_reg : last_fault_reg;
  assign fault_count = fault_count_reg;

`ifdef IMEM_PREFETCH_EN
  logic          pf_valid_reg;
  logic [31:0]   pf_tag_reg;
  logic [31:0]   pf_data_reg;
  logic [29:0]   word_reg;
  logic [30:0]   next_word;
  logic [AW-1:0] next_idx;
  logic          next_in_range;
  logic          pf_hit;

  assign next_word     = {1'b0, word_reg} + 31'd1;
  assign next_idx      = next_word[AW-1:0];
  assign next_in_range = next_word < 31'(DEPTH);
  // The buffer is cleared on a flush, so a request that comes with a flush never hits.
  assign pf_hit        = accept && !flush && pf_valid_reg && (req_addr == pf_tag_reg);
  assign fast_path     = (LATENCY == 1) || pf_hit;

  // Prefetch buffer: after a good response, capture the next sequential word.
  // The buffer is dropped when its word is overwritten.
  always_ff @(posedge clk) begin
    if (accept) word_reg <= req_addr[31:2];
    if (rsp_valid && !fault_reg && next_in_range) begin
      pf_data_reg <= mem[next_idx];
      pf_tag_reg  <= {next_word[29:0], 2'b00};
    end
    if (rst || flush)
      pf_valid_reg <= 1'b0;
    else if (rsp_valid && !fault_reg)
      pf_valid_reg <= next_in_range && !(load_en && load_addr == next_idx);
    else if (load_en && load_addr == pf_tag_reg[AW+1:2])
      pf_valid_reg <= 1'b0;
  end
`else
  assign fast_path = (LATENCY == 1);
`endif

  // Next-state logic. A new accept takes priority, then a flush, then the normal sequence.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (accept) begin
      if (fast_path) begin
        state_next = RESP;
      end else begin
        state_next = WAIT;
        cnt_next   = 3'(LATENCY - 1);
      end
    end else if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        WAIT: begin
          cnt_next = cnt_reg - 3'd1;
          if (cnt_reg == 3'd1) state_next = RESP;
        end
        RESP:    state_next = IDLE;
        default: state_next = state_reg;
      endcase
    end
  end

  // State and latency counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Store write port. Loads are taken in every cycle, whatever the state.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  // Registered read at accept. A load to the same index in that cycle still
  // returns the old word. Later loads leave the held word unchanged.
  always_ff @(posedge clk) begin
    if (accept) begin
`ifdef IMEM_PREFETCH_EN
      if (pf_hit) begin
        data_reg  <= pf_data_reg;
        fault_reg <= 1'b0;
      end else begin
        data_reg  <= mem[req_idx];
        fault_reg <= req_fault;
      end
`else
      data_reg  <= mem[req_idx];
      fault_reg <= req_fault;
`endif
    end
  end

  // Keep the last response for the hold behaviour, and count delivered faults (saturating).
  always_ff @(posedge clk) begin
    if (rst) begin
      last_instr_reg  <= 32'd0;
      last_fault_reg  <= 1'b0;
      fault_count_reg <= 8'd0;
    end else if (rsp_valid) begin
      last_instr_reg <= rsp_instr;
      last_fault_reg <= fault_reg;
      if (fault_reg && fault_count_reg != 8'hFF)
        fault_count_reg <= fault_count_reg + 8'd1;
    end
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory side of the fetch interface. It accepts a program-counter fetch request and returns a 32-bit instruction word after a fixed latency.
- Holds a word-addressed instruction store. The store is programmed through a load port while the core is held or running.
- A redirect (taken branch from EXE) flushes any in-flight fetch. Out-of-range or misaligned fetches return a NOP with a fault flag.

Parameters:
- DEPTH, 256, number of 32-bit instruction words (power of two, 16..4096)
- LATENCY, 2, cycles from request acceptance to rsp_valid (1..4)
- NOP_WORD, 32'hC8000000, word returned on fault (opcode [31:25] = 7'b1100100)

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  fetch request present
- req_addr  in  32  byte address (programCounter from fetch)
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- flush  in  1  redirect: discard in-flight fetch
- rsp_valid  out  1  one-cycle pulse: rsp_instr valid
- rsp_instr  out  32  fetched instruction
- rsp_fault  out  1  qualifies rsp_valid: address misaligned or >= DEPTH*4
- load_en  in  1  write one word into the store
- load_addr  in  $clog2(DEPTH)  word index for load
- load_data  in  32  word to write
- fault_count  out  8  saturating count of faulted responses

Behaviour:
- Reset: rsp_valid=0, rsp_instr=0, rsp_fault=0, fault_count=0, state=IDLE, req_ready=1 in the cycle after rst falls. Store contents are not cleared. rst mid-operation drops any in-flight fetch with no response.
- States:
  - IDLE: req_ready=1. On accept, go to WAIT with a latency counter set to LATENCY-1; if LATENCY==1, go directly to RESP.
  - WAIT: req_ready=0. Counter decrements each cycle; at 0, go to RESP.
  - RESP: rsp_valid=1 for exactly this cycle. req_ready=1, so a back-to-back accept re-enters WAIT/RESP; otherwise go to IDLE.
- Latency: accept in cycle N gives rsp_valid in cycle N+LATENCY. Sustained throughput is one fetch per LATENCY cycles.
- Address handling:
  - Word index = req_addr[$clog2(DEPTH)+1:2].
  - Fault if req_addr[1:0]!=0 or req_addr[31:2] >= DEPTH. A faulted fetch returns NOP_WORD with rsp_fault=1.
- Read timing: the store is read in the accept cycle and the word is held internally until RESP.
- Load/read collision:
  - A load to the same index in the accept cycle returns the old word.
  - A later load does not alter a held word.
- Loads are accepted every cycle regardless of state.
- Flush:
  - When flush=1, any fetch in WAIT or RESP is discarded and rsp_valid is forced 0 that cycle. req_ready=1 that cycle.
  - A request presented with flush is accepted as the redirect target.
  - flush in IDLE with no request has no effect.
- rsp_instr and rsp_fault hold their last values when rsp_valid=0.
- fault_count increments on each rsp_valid&&rsp_fault and saturates at 255. Flushed faults are not counted.

Optional Feature:
- Macro IMEM_PREFETCH_EN.
- Defined:
  - After each non-faulted response for address A, the block reads word A+4 into a one-entry prefetch buffer (tag + data, valid bit).
  - An accepted request whose address equals the tag hits: rsp_valid comes in the next cycle (latency 1), bypassing WAIT.
  - The buffer is invalidated on flush, rst, or a load to the tagged index. A miss uses normal LATENCY.
- Not defined: no buffer; every fetch takes LATENCY cycles.

Test Plan:
- Load word 0x00A00005 at index 0, rst low, request addr 0x0 at cycle N (LATENCY=2) -> rsp_valid at N+2 only, rsp_instr=0x00A00005, rsp_fault=0.
- Back-to-back requests 0x0,0x4,0x8, each accepted in its RESP cycle -> three responses spaced 2 cycles apart, in order, req_ready low during WAIT.
- Request 0x402 (misaligned) then 0x400 with DEPTH=256 -> both return 0xC8000000, rsp_fault=1, fault_count=2.
- Request 0x10, assert flush one cycle later with req_addr=0x40 -> no response for 0x10; word[16] returned 2 cycles after flush.
- Same-cycle load index 3 = 0xDEADBEEF and request 0xC holding 0x11111111 -> response 0x11111111; a repeat request returns 0xDEADBEEF.
- IMEM_PREFETCH_EN: request 0x20 then 0x24 -> second response one cycle after accept; 0x24 after a flush -> full LATENCY.
